gate_test_sequencer: RTL and testbench

Self-checking stimulus controller for a 2-input combinational gate under test, such as the team's and_gate.
- Walks all four input vectors through the gate, holds each for a programmable settle time, and samples the gate output.
- Compares each sample against a parameterised truth table and reports an error count plus pass/fail.
- Sits between a bench or BIST controller (start/done handshake) and the gate's inputs and output.

---
 rtl/gate_seq_pkg.sv | 18 +
 rtl/gate_seq_timer.sv | 27 ++
 rtl/gate_test_sequencer.sv | 135 +++++++++++++
 tb/tb_gate_test_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate test sequencer: FSM state encoding,
// vector width and the default AND truth table.
package gate_seq_pkg;

   localparam int VEC_W = 2;

   // Expected output indexed by {a,b}; only {1,1} yields 1 for AND
   localparam logic [3:0] TRUTH_AND = 4'b1000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

endpackage

// File: rtl/gate_seq_timer.sv
// Loadable down-counter with enable and zero flag; times the settle window.
module gate_seq_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Walks all four {a,b} vectors through a 2-input gate and scores the outputs.
// Optional first-failure capture ports are enabled by GATE_SEQ_FIRST_FAIL_EN.
module gate_test_sequencer
   import gate_seq_pkg::*;
#(
   parameter int         SETTLE_CYC = 4,
   parameter logic [3:0] TRUTH      = TRUTH_AND,
   parameter int         PASSES     = 1,
   parameter int         ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             dut_a,
   output logic             dut_b,
   input  logic             dut_y,
   output logic [ERR_W-1:0] err_cnt,
   output logic [VEC_W-1:0] vec_idx
`ifdef GATE_SEQ_FIRST_FAIL_EN
   ,
   output logic             fail_vld,
   output logic [VEC_W-1:0] fail_vec,
   output logic             fail_y
`endif
);

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

   state_t           state;
   logic [7:0]       pass_cnt;
   logic             timer_zero;
   logic             mismatch;
   logic [ERR_W-1:0] err_next;

   gate_seq_timer #(
      .W(8)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == S_DRIVE),
      .en       (state == S_SETTLE),
      .load_val (SETTLE_LOAD),
      .zero     (timer_zero)
   );

   assign mismatch = (dut_y != TRUTH[vec_idx]);
   // Saturate rather than wrap so a long failing run never reads as clean
   assign err_next = (mismatch && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         dut_a    <= 1'b0;
         dut_b    <= 1'b0;
         err_cnt  <= '0;
         vec_idx  <= '0;
         pass_cnt <= '0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
         fail_vld <= 1'b0;
         fail_vec <= '0;
         fail_y   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  err_cnt  <= '0;
                  pass     <= 1'b0;
                  vec_idx  <= '0;
                  pass_cnt <= '0;
                  dut_a    <= 1'b0;
                  dut_b    <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_DRIVE;
`ifdef GATE_SEQ_FIRST_FAIL_EN
                  fail_vld <= 1'b0;
                  fail_vec <= '0;
                  fail_y   <= 1'b0;
`endif
               end
            end
            S_DRIVE: begin
               state <= S_SETTLE;
            end
            S_SETTLE: begin
               if (timer_zero) begin
                  state <= S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               err_cnt <= err_next;
`ifdef GATE_SEQ_FIRST_FAIL_EN
               if (mismatch && !fail_vld) begin
                  fail_vld <= 1'b1;
                  fail_vec <= vec_idx;
                  fail_y   <= dut_y;
               end
`endif
               // The next vector goes onto the gate on the same edge it is selected
               if (vec_idx != 2'd3) begin
                  vec_idx          <= vec_idx + 2'd1;
                  {dut_a, dut_b}   <= vec_idx + 2'd1;
                  state            <= S_DRIVE;
               end else if (pass_cnt < PASS_LAST) begin
                  pass_cnt         <= pass_cnt + 8'd1;
                  vec_idx          <= '0;
                  {dut_a, dut_b}   <= 2'b00;
                  state            <= S_DRIVE;
               end else begin
                  {dut_a, dut_b}   <= 2'b00;
                  busy             <= 1'b0;
                  done             <= 1'b1;
                  pass             <= (err_next == '0);
                  state            <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: default, 3-pass and 2-bit-counter
// instances driven by behavioural gate models (AND, stuck-at-1, stuck-at-0).
module tb_gate_test_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] start;
   logic [2:0] busy, done, pass, dut_a, dut_b, dut_y;
   logic [1:0] vec_idx [3];
   logic [7:0] err_m, err_p;
   logic [1:0] err_s;
   logic [2:0] fail_vld, fail_y;
   logic [1:0] fail_vec [3];
   int         mode [3];
   int         sel;
   int         n_checks = 0;
   int         n_errors = 0;

   logic       busy_mon, done_mon, pass_mon, a_mon, b_mon;
   logic [1:0] vec_mon;
   logic [7:0] err_mon;

   always #5 clk = ~clk;

   // Gate models: 0 = AND, 1 = stuck-at-1, 2 = stuck-at-0
   function automatic logic gate_model(input int m, input logic a, input logic b);
      case (m)
         1:       return 1'b1;
         2:       return 1'b0;
         default: return a & b;
      endcase
   endfunction

   always_comb begin
      dut_y = '0;
      for (int i = 0; i < 3; i++) dut_y[i] = gate_model(mode[i], dut_a[i], dut_b[i]);
   end

   always_comb begin
      busy_mon = busy[sel[1:0]];
      done_mon = done[sel[1:0]];
      pass_mon = pass[sel[1:0]];
      a_mon    = dut_a[sel[1:0]];
      b_mon    = dut_b[sel[1:0]];
      vec_mon  = vec_idx[sel[1:0]];
      case (sel)
         1:       err_mon = err_p;
         2:       err_mon = {6'd0, err_s};
         default: err_mon = err_m;
      endcase
   end

   gate_test_sequencer dut_main (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .dut_a(dut_a[0]), .dut_b(dut_b[0]), .dut_y(dut_y[0]),
      .err_cnt(err_m), .vec_idx(vec_idx[0])
`ifdef GATE_SEQ_FIRST_FAIL_EN
      , .fail_vld(fail_vld[0]), .fail_vec(fail_vec[0]), .fail_y(fail_y[0])
`endif
   );

   gate_test_sequencer #(.PASSES(3)) dut_p3 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .dut_a(dut_a[1]), .dut_b(dut_b[1]), .dut_y(dut_y[1]),
      .err_cnt(err_p), .vec_idx(vec_idx[1])
`ifdef GATE_SEQ_FIRST_FAIL_EN
      , .fail_vld(fail_vld[1]), .fail_vec(fail_vec[1]), .fail_y(fail_y[1])
`endif
   );

   gate_test_sequencer #(.PASSES(2), .ERR_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
      .pass(pass[2]), .dut_a(dut_a[2]), .dut_b(dut_b[2]), .dut_y(dut_y[2]),
      .err_cnt(err_s), .vec_idx(vec_idx[2])
`ifdef GATE_SEQ_FIRST_FAIL_EN
      , .fail_vld(fail_vld[2]), .fail_vec(fail_vec[2]), .fail_y(fail_y[2])
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Pulses start on instance s and follows the run edge by edge (edge 0 = accept)
   task automatic applyStimulus(input int s, input int m, input int exp_done,
                                output int done_edge, output int busy_cyc, output int vec_bad);
      logic [1:0] ev;
      sel       = s;
      mode[s]   = m;
      done_edge = -1;
      busy_cyc  = 0;
      vec_bad   = 0;
      @(negedge clk);
      start[s] = 1'b1;
      @(posedge clk);
      for (int e = 0; e < 400; e++) begin
         @(negedge clk);
         start[s] = 1'b0;
         if (busy_mon) busy_cyc++;
         ev = 2'((e / 6) % 4);
         if (e < exp_done && ({a_mon, b_mon} != ev || vec_mon != ev)) vec_bad++;
         if (done_mon) begin
            done_edge = e;
            break;
         end
         @(posedge clk);
      end
   endtask

   initial begin
      int d, b, v, acc1, acc2, n_acc, n_done;
      logic prev_busy, drained;
      rst_n = 1'b0;
      start = '0;
      sel   = 0;
      for (int i = 0; i < 3; i++) mode[i] = 0;

      #22;
      checkOutput("reset_ctrl", {busy[0], done[0], pass[0], dut_a[0], dut_b[0]}, 0);
      checkOutput("reset_cnt", {err_m, vec_idx[0]}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] AND gate, defaults");
      applyStimulus(0, 0, 24, d, b, v);
      checkOutput("and_done_edge", d, 24);
      checkOutput("and_busy_cycles", b, 24);
      checkOutput("and_vectors", v, 0);
      checkOutput("and_err", err_mon, 0);
      checkOutput("and_pass", pass_mon, 1);
      @(negedge clk);
      checkOutput("and_done_pulse", {done_mon, busy_mon, pass_mon}, 3'b001);

      $display("[TB] stuck-at-1, defaults");
      applyStimulus(0, 1, 24, d, b, v);
      checkOutput("sa1_done_edge", d, 24);
      checkOutput("sa1_err", err_mon, 3);
      checkOutput("sa1_pass", pass_mon, 0);
`ifdef GATE_SEQ_FIRST_FAIL_EN
      checkOutput("sa1_first_fail", {fail_vld[0], fail_vec[0], fail_y[0]}, 4'b1001);
`endif

      $display("[TB] stuck-at-0, PASSES=3");
      applyStimulus(1, 2, 72, d, b, v);
      checkOutput("p3_done_edge", d, 72);
      checkOutput("p3_vectors", v, 0);
      checkOutput("p3_err", err_mon, 3);
      checkOutput("p3_pass", pass_mon, 0);

      $display("[TB] stuck-at-1, ERR_W=2, PASSES=2");
      applyStimulus(2, 1, 48, d, b, v);
      checkOutput("sat_done_edge", d, 48);
      checkOutput("sat_err", err_mon, 3);
      checkOutput("sat_pass", pass_mon, 0);

      $display("[TB] reset during SETTLE of vector 2");
      sel     = 0;
      mode[0] = 1;
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[0] = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      checkOutput("mid_err", err_m, 2);
      checkOutput("mid_vec", vec_idx[0], 2);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset", {busy[0], done[0], pass[0], dut_a[0], dut_b[0], vec_idx[0], err_m}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 0, 24, d, b, v);
      checkOutput("fresh_done_edge", d, 24);
      checkOutput("fresh_vectors", v, 0);
      checkOutput("fresh_err", err_mon, 0);
      checkOutput("fresh_pass", pass_mon, 1);

      $display("[TB] start held high for 60 cycles");
      sel       = 0;
      mode[0]   = 0;
      acc1      = -1;
      acc2      = -1;
      n_acc     = 0;
      n_done    = 0;
      prev_busy = 1'b0;
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk);
      for (int e = 0; e < 60; e++) begin
         @(negedge clk);
         if (busy_mon && !prev_busy) begin
            if (n_acc == 0) acc1 = e;
            else if (n_acc == 1) acc2 = e;
            n_acc++;
         end
         prev_busy = busy_mon;
         if (done_mon) n_done++;
         if (e == 59) start[0] = 1'b0;
         @(posedge clk);
      end
      checkOutput("held_accept_1", acc1, 0);
      checkOutput("held_accept_2", acc2, 26);
      checkOutput("held_done_count", n_done, 2);
      drained = 1'b0;
      for (int e = 0; e < 100; e++) begin
         @(negedge clk);
         if (done_mon) begin
            drained = 1'b1;
            break;
         end
      end
      checkOutput("held_drain", drained, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
